// File: rtl/uart_pkg.sv
// Shared constants and drain-FSM encoding for the UART echo path.
// Latency: none (declarations and pure functions only).
// Backpressure: n/a. Case-swap helpers are only called when UART_ECHO_CASE_SWAP_EN is defined.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [DATA_BITS-1:0] ASCII_UC_LO = 8'h41;
    localparam logic [DATA_BITS-1:0] ASCII_UC_HI = 8'h5A;
    localparam logic [DATA_BITS-1:0] ASCII_LC_LO = 8'h61;
    localparam logic [DATA_BITS-1:0] ASCII_LC_HI = 8'h7A;

    // Drain FSM: IDLE issues a byte, START waits for the transmitter to take it,
    // BUSY waits for the transmitter to free up again.
    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_START = 2'd1,
        DRAIN_BUSY  = 2'd2
    } drain_state_t;

    function automatic logic is_ascii_letter(input logic [DATA_BITS-1:0] b);
        return ((b >= ASCII_UC_LO) && (b <= ASCII_UC_HI)) ||
               ((b >= ASCII_LC_LO) && (b <= ASCII_LC_HI));
    endfunction

    // Upper/lower case differ only in bit 5 for ASCII letters.
    function automatic logic [DATA_BITS-1:0] case_swap(input logic [DATA_BITS-1:0] b);
        return is_ascii_letter(b) ? (b ^ 8'h20) : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data (dout is the current head).
// Latency: a write is visible on dout/empty the cycle after push.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // At full a simultaneous pop frees the slot being written, so both proceed.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchroniser and mid-bit sampling.
// Latency: data_ready pulses one cycle after the mid-stop-bit sample.
// Backpressure: none; the consumer must take data on the data_ready pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_ready
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t            state;
    logic                 rx_m;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // Synchronise the line, find the start edge, then sample each bit at its centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            data_ready <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            data_ready <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == CNT_W'(CPB/2 - 1)) begin
                        cnt   <= '0;
                        state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s) begin
                            data       <= shreg;
                            data_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; the line is a register forced high by the async reset.
// Latency: start bit appears on tx the cycle after en is sampled in idle.
// Backpressure: ready is high in idle and in the final cycle of the stop bit; en is only honoured in idle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 ready
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // Raising ready in the last stop cycle lets the next byte follow with a minimal idle gap.
    assign ready = (state == TX_IDLE) ||
                   ((state == TX_STOP) && (cnt == CNT_W'(CPB - 1)));

    // Shift the frame out LSB first, each bit held for CPB cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (en) begin
                        shreg <= data;
                        tx    <= 1'b0;
                        cnt   <= '0;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt     <= '0;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                        bit_idx <= '0;
                        state   <= TX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt <= '0;
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt   <= '0;
                        state <= TX_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo: received bytes go through a FIFO and are re-sent on tx; optional case swap via UART_ECHO_CASE_SWAP_EN.
// Latency: byte pushed on data_ready, popped the next cycle at the earliest, start bit two cycles after the pop.
// Backpressure: FIFO absorbs tx stalls; a byte arriving at full with no pop is dropped and latches overflow.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int BAUD   = 9600,
    parameter int CLK_HZ = 12000000,
    parameter int DEPTH  = 16,
    parameter int LED_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    output logic                       tx,
    output logic [LED_W-1:0]           leds,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    logic [1:0]           rst_pipe;
    logic                 rst_sync_n;
    logic                 rst_sync;

    logic [DATA_BITS-1:0] rx_dat;
    logic                 rx_vld;
    logic                 tx_rdy;
    logic                 tx_en;
    logic [DATA_BITS-1:0] tx_dat;
    logic [DATA_BITS-1:0] tx_byte;

    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    drain_state_t         drain_state;

    // Reset asserts asynchronously everywhere but releases only on a clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe[1];
    assign rst_sync   = ~rst_sync_n;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst        (rst_sync),
        .rx         (rx),
        .data       (rx_dat),
        .data_ready (rx_vld)
    );

    uart_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_tx (
        .clk   (clk),
        .rst   (rst_sync),
        .en    (tx_en),
        .data  (tx_dat),
        .tx    (tx),
        .ready (tx_rdy)
    );

    // Pop only from IDLE; at full, a same-cycle pop makes room for the arriving byte.
    assign pop  = (drain_state == DRAIN_IDLE) && !fifo_empty && tx_rdy;
    assign push = rx_vld && (!fifo_full || pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .push  (push),
        .pop   (pop),
        .din   (rx_dat),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

`ifdef UART_ECHO_CASE_SWAP_EN
    assign tx_byte = case_swap(fifo_dout);
`else
    assign tx_byte = fifo_dout;
`endif

    // LEDs mirror the last accepted byte; overflow latches on any dropped byte.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            leds     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                leds <= rx_dat[LED_W-1:0];
            end
            if (rx_vld && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Drain FSM: one en pulse per popped byte, then track the transmitter through its frame.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            drain_state <= DRAIN_IDLE;
            tx_en       <= 1'b0;
            tx_dat      <= '0;
        end else begin
            tx_en <= 1'b0;
            case (drain_state)
                DRAIN_IDLE: begin
                    if (pop) begin
                        tx_en       <= 1'b1;
                        tx_dat      <= tx_byte;
                        drain_state <= DRAIN_START;
                    end
                end
                DRAIN_START: begin
                    if (!tx_rdy) drain_state <= DRAIN_BUSY;
                end
                DRAIN_BUSY: begin
                    if (tx_rdy) drain_state <= DRAIN_IDLE;
                end
                default: drain_state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule
